// File: rtl/game_timer_pkg.sv
// Shared types and BCD helpers for the MM:SS game timer.
package game_timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0]  SEC_TENS_MAX = 4'd5;
  localparam logic [3:0]  DIGIT_MAX    = 4'd9;
  localparam logic [15:0] TIME_MAX     = 16'h9959;

  function automatic logic [3:0] clamp_digit(
    input logic [3:0] d,
    input logic [3:0] lim
  );
    return (d > lim) ? lim : d;
  endfunction

  function automatic logic [15:0] clamp_bcd(
    input logic [15:0] v
  );
    return {clamp_digit(v[15:12], DIGIT_MAX),
            clamp_digit(v[11:8], DIGIT_MAX),
            clamp_digit(v[7:4], SEC_TENS_MAX),
            clamp_digit(v[3:0], DIGIT_MAX)};
  endfunction

endpackage

// File: rtl/game_timer_ctrl_step.sv
// One-second BCD MM:SS increment/decrement, purely combinational.
import game_timer_pkg::*;

module bcd_mmss_step (
  input  logic [15:0] time_bcd,
  input  logic        dir,
  output logic [15:0] next_bcd,
  output logic        at_max,
  output logic        at_zero
);

  assign at_max  = (time_bcd == TIME_MAX);
  assign at_zero = (time_bcd == 16'h0000);

  always_comb begin
    logic       carry;
    logic [3:0] lim;
    logic [3:0] d;
    logic [3:0] nd;
    carry    = 1'b1;
    lim      = DIGIT_MAX;
    d        = 4'd0;
    nd       = 4'd0;
    next_bcd = time_bcd;
    for (int i = 0; i < 4; i++) begin
      lim = (i == 1) ? SEC_TENS_MAX : DIGIT_MAX;
      d   = time_bcd[4*i +: 4];
      nd  = d;
      if (carry) begin
        if (!dir) begin
          if (d >= lim) begin
            nd = 4'd0;
          end else begin
            nd    = d + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (d == 4'd0) begin
            nd = lim;
          end else begin
            nd    = d - 4'd1;
            carry = 1'b0;
          end
        end
      end
      next_bcd[4*i +: 4] = nd;
    end
    // 00:00 is the floor when counting down
    if (dir && at_zero) next_bcd = 16'h0000;
  end

endmodule

// File: rtl/game_timer_ctrl.sv
// Frame-driven MM:SS game timer: up/down count, pause,
// load/clear, saturate or wrap, expiry and best-time tracking.
import game_timer_pkg::*;

module game_timer_ctrl #(
  parameter int unsigned FRAMES_PER_SEC = 60,
  parameter bit          VSYNC_RISE     = 1'b1,
  parameter bit          WRAP_UP        = 1'b0,
  parameter bit          BEST_IS_MAX    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync,
  input  logic        run,
  input  logic        pause,
  input  logic        mode_down,
  input  logic        clear,
  input  logic        load,
  input  logic [15:0] load_bcd,
  output logic [15:0] time_bcd,
  output logic [15:0] best_bcd,
  output logic        new_best,
  output logic        expired,
  output logic        saturated,
  output logic [1:0]  state_out
);

  localparam logic [7:0] FPS_LAST =
    8'(FRAMES_PER_SEC - 1);

  state_t      state;
  state_t      state_d;
  logic        mode_q;
  logic        prev_vsync;
  logic [7:0]  frame_cnt;
  logic [7:0]  frame_d;
  logic [15:0] time_q;
  logic [15:0] time_d;
  logic [15:0] best_q;
  logic        nb_q;
  logic        sat_q;
  logic        sat_d;

  logic        tick;
  logic        step;
  logic        pinned;
  logic        done_hit;
  logic        session_end;
  logic        better;
  logic        best_upd;
  logic [15:0] next_bcd;
  logic        at_max;
  logic        at_zero;

  assign tick = VSYNC_RISE ? (vsync & ~prev_vsync)
                           : (~vsync & prev_vsync);

  // a tick coincident with clear is dropped
  assign step = (state == RUN) && tick && !clear
              && (frame_cnt == FPS_LAST);

  bcd_mmss_step u_step (
    .time_bcd (time_q),
    .dir      (mode_q),
    .next_bcd (next_bcd),
    .at_max   (at_max),
    .at_zero  (at_zero)
  );

  assign pinned   = !mode_q && at_max && !WRAP_UP;
  assign done_hit = mode_q
                  && (at_zero || (step && next_bcd == 16'h0000));

  assign session_end = ((state == RUN) || (state == PAUSE))
                     && !run;

  always_comb begin
    better = 1'b0;
    if (BEST_IS_MAX) begin
      better = (time_q > best_q);
    end else begin
      better = (time_q != 16'h0000)
             && ((best_q == 16'h0000) || (time_q < best_q));
    end
  end

  assign best_upd = session_end && !mode_q && better;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (run) state_d = (mode_q && at_zero) ? DONE : RUN;
      end
      RUN: begin
        if (!run)          state_d = IDLE;
        else if (pause)    state_d = PAUSE;
        else if (done_hit) state_d = DONE;
      end
      PAUSE: begin
        if (!run)        state_d = IDLE;
        else if (!pause) state_d = RUN;
      end
      DONE: begin
        if (clear || !run) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    time_d  = time_q;
    frame_d = frame_cnt;
    sat_d   = sat_q;
    if ((state == RUN) && tick) begin
      frame_d = (frame_cnt == FPS_LAST) ? 8'd0
                                        : frame_cnt + 8'd1;
    end
    if ((state == IDLE) && (state_d == RUN)) frame_d = 8'd0;
    if (step) begin
      time_d = pinned ? time_q : next_bcd;
      sat_d  = pinned;
    end
    if (clear) begin
      time_d  = 16'h0000;
      frame_d = 8'd0;
      sat_d   = 1'b0;
    end else if ((state == IDLE) && load) begin
      time_d = clamp_bcd(load_bcd);
      sat_d  = 1'b0;
    end
    if (state_d == DONE) time_d = 16'h0000;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_vsync <= 1'b0;
      mode_q     <= 1'b0;
      frame_cnt  <= 8'd0;
      time_q     <= 16'h0000;
      best_q     <= 16'h0000;
      nb_q       <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      prev_vsync <= vsync;
      if (state == IDLE) mode_q <= mode_down;
      frame_cnt  <= frame_d;
      time_q     <= time_d;
      sat_q      <= sat_d;
      nb_q       <= best_upd;
      if (best_upd) best_q <= time_q;
    end
  end

  assign time_bcd  = time_q;
  assign best_bcd  = best_q;
  assign new_best  = nb_q;
  assign expired   = (state == DONE);
  assign saturated = sat_q;
  assign state_out = state;

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Self-checking bench for game_timer_ctrl: directed sequences,
// a load-clamp table and random stimulus against a seconds-level model.
module tb_game_timer_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vsync = 1'b0;
  logic        run = 1'b0;
  logic        pause = 1'b0;
  logic        mode_down = 1'b0;
  logic        clear = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_bcd = 16'h0000;

  logic [15:0] t1, b1, t2, b2;
  logic        nb1, ex1, sat1, nb2, ex2, sat2;
  logic [1:0]  st1, st2;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  game_timer_ctrl dut (
    .clk(clk), .rst(rst), .vsync(vsync), .run(run),
    .pause(pause), .mode_down(mode_down), .clear(clear),
    .load(load), .load_bcd(load_bcd), .time_bcd(t1),
    .best_bcd(b1), .new_best(nb1), .expired(ex1),
    .saturated(sat1), .state_out(st1)
  );

  game_timer_ctrl #(
    .FRAMES_PER_SEC(3), .VSYNC_RISE(1'b1),
    .WRAP_UP(1'b1), .BEST_IS_MAX(1'b0)
  ) dut2 (
    .clk(clk), .rst(rst), .vsync(vsync), .run(run),
    .pause(pause), .mode_down(mode_down), .clear(clear),
    .load(load), .load_bcd(load_bcd), .time_bcd(t2),
    .best_bcd(b2), .new_best(nb2), .expired(ex2),
    .saturated(sat2), .state_out(st2)
  );

  // Reference model: time kept as plain seconds 0..5999
  typedef struct {
    int st;
    bit mode;
    int secs;
    int frames;
    bit pv;
    int best;
    bit nb;
    bit sat;
  } mdl_t;

  mdl_t m1, m2;

  function automatic int clampsec(input logic [15:0] v);
    int d3, d2, d1, d0;
    d3 = int'(v[15:12]); d2 = int'(v[11:8]);
    d1 = int'(v[7:4]);   d0 = int'(v[3:0]);
    if (d3 > 9) d3 = 9;
    if (d2 > 9) d2 = 9;
    if (d1 > 5) d1 = 5;
    if (d0 > 9) d0 = 9;
    return (d3 * 10 + d2) * 60 + d1 * 10 + d0;
  endfunction

  function automatic logic [15:0] to_bcd(input int s);
    int mm, ss;
    mm = s / 60;
    ss = s % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic mdl_t mstep(
    input mdl_t m, input int fps, input bit wrap,
    input bit bmax, input bit v, input bit r,
    input bit p, input bit md, input bit clr,
    input bit ld, input logic [15:0] lb
  );
    mdl_t n;
    bit tk, stepped, send, upd;
    int old;
    n = m;
    tk = v && !m.pv;
    stepped = 0;
    send = 0;
    old = m.secs;
    n.pv = v;
    n.nb = 0;
    case (m.st)
      0: begin
        n.mode = md;
        if (clr) begin
          n.secs = 0; n.frames = 0; n.sat = 0;
        end else if (ld) begin
          n.secs = clampsec(lb); n.sat = 0;
        end
        if (r) begin
          if (m.mode && old == 0) n.st = 3;
          else begin n.st = 1; n.frames = 0; end
        end
      end
      1: begin
        if (clr) begin
          n.secs = 0; n.frames = 0; n.sat = 0;
        end else if (tk) begin
          if (m.frames == fps - 1) begin
            n.frames = 0; stepped = 1;
          end else n.frames = m.frames + 1;
        end
        if (stepped && !m.mode) begin
          if (old == 5999) begin
            if (wrap) begin n.secs = 0; n.sat = 0; end
            else n.sat = 1;
          end else begin
            n.secs = old + 1; n.sat = 0;
          end
        end else if (stepped) begin
          if (old > 0) n.secs = old - 1;
          n.sat = 0;
        end
        if (!r) begin n.st = 0; send = 1; end
        else if (p) n.st = 2;
        else if (m.mode && (old == 0 || (stepped && n.secs == 0)))
          n.st = 3;
      end
      2: begin
        if (clr) begin
          n.secs = 0; n.frames = 0; n.sat = 0;
        end
        if (!r) begin n.st = 0; send = 1; end
        else if (!p) n.st = 1;
      end
      default: begin
        if (clr) begin n.frames = 0; n.sat = 0; end
        if (clr || !r) n.st = 0;
      end
    endcase
    if (send && !m.mode) begin
      if (bmax) upd = (old > m.best);
      else upd = (old != 0) && (m.best == 0 || old < m.best);
      if (upd) begin n.best = old; n.nb = 1; end
    end
    if (n.st == 3) n.secs = 0;
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m1 <= '{default: 0};
      m2 <= '{default: 0};
    end else begin
      m1 <= mstep(m1, 60, 1'b0, 1'b1, vsync, run, pause,
                  mode_down, clear, load, load_bcd);
      m2 <= mstep(m2, 3, 1'b1, 1'b0, vsync, run, pause,
                  mode_down, clear, load, load_bcd);
    end
  end

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_models();
    chk("m1.time", t1, to_bcd(m1.secs));
    chk("m1.best", b1, to_bcd(m1.best));
    chk("m1.new_best", {15'd0, nb1}, {15'd0, m1.nb});
    chk("m1.expired", {15'd0, ex1}, {15'd0, m1.st == 3});
    chk("m1.sat", {15'd0, sat1}, {15'd0, m1.sat});
    chk("m1.state", {14'd0, st1}, 16'(m1.st));
    chk("m2.time", t2, to_bcd(m2.secs));
    chk("m2.best", b2, to_bcd(m2.best));
    chk("m2.new_best", {15'd0, nb2}, {15'd0, m2.nb});
    chk("m2.expired", {15'd0, ex2}, {15'd0, m2.st == 3});
    chk("m2.sat", {15'd0, sat2}, {15'd0, m2.sat});
    chk("m2.state", {14'd0, st2}, 16'(m2.st));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      vsync = 1'b1;
      @(negedge clk);
      vsync = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic pulse_load(input logic [15:0] v);
    load_bcd = v;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  typedef struct {
    logic [15:0] ld;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{16'hFFFF, 16'h9959};
    vecs[1] = '{16'h0003, 16'h0003};
    vecs[2] = '{16'h9958, 16'h9958};
    vecs[3] = '{16'h0A7C, 16'h0959};
    vecs[4] = '{16'h1234, 16'h1234};
    vecs[5] = '{16'h5F60, 16'h5950};
    vecs[6] = '{16'h00F0, 16'h0050};
    vecs[7] = '{16'h7777, 16'h7757};

    #2 rst = 1'b0;
    #1;
    chk("rst.time", t1, 16'h0000);
    chk("rst.best", b1, 16'h0000);
    chk("rst.state", {14'd0, st1}, 16'd0);
    chk("rst.flags", {13'd0, nb1, ex1, sat1}, 16'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // up count 1 s, 1 min, 1:30 then session end
    run = 1'b1;
    @(negedge clk);
    ticks(60);
    chk("up.0001", t1, 16'h0001);
    ticks(3540);
    chk("up.0100", t1, 16'h0100);
    ticks(1800);
    chk("up.0130", t1, 16'h0130);
    chk("wrap.3000", t2, 16'h3000);
    run = 1'b0;
    @(negedge clk);
    chk("best.0130", b1, 16'h0130);
    chk("best.pulse", {15'd0, nb1}, 16'd1);
    chk("best.min3000", b2, 16'h3000);
    @(negedge clk);
    chk("best.pulse1cyc", {15'd0, nb1}, 16'd0);

    pulse_clear();
    run = 1'b1;
    @(negedge clk);
    ticks(2700);
    chk("up.0045", t1, 16'h0045);
    run = 1'b0;
    @(negedge clk);
    chk("best.keep", b1, 16'h0130);
    chk("best.nopulse", {15'd0, nb1}, 16'd0);
    chk("best.min1500", b2, 16'h1500);

    // countdown from 00:03
    mode_down = 1'b1;
    pulse_load(16'h0003);
    run = 1'b1;
    @(negedge clk);
    ticks(60);
    chk("dn.0002", t1, 16'h0002);
    ticks(60);
    chk("dn.0001", t1, 16'h0001);
    ticks(59);
    chk("dn.state_run", {14'd0, st1}, 16'd1);
    ticks(1);
    chk("dn.0000", t1, 16'h0000);
    chk("dn.expired", {15'd0, ex1}, 16'd1);
    chk("dn.state_done", {14'd0, st1}, 16'd3);
    chk("dn2.expired", {15'd0, ex2}, 16'd1);
    run = 1'b0;
    @(negedge clk);
    chk("dn.exp_clr", {15'd0, ex1}, 16'd0);
    chk("dn.state_idle", {14'd0, st1}, 16'd0);

    // saturation / wrap at 99:59
    mode_down = 1'b0;
    @(negedge clk);
    pulse_load(16'h9958);
    run = 1'b1;
    @(negedge clk);
    ticks(120);
    chk("sat.time", t1, 16'h9959);
    chk("sat.flag", {15'd0, sat1}, 16'd1);
    chk("wrap.time", t2, 16'h0038);
    chk("wrap.sat", {15'd0, sat2}, 16'd0);
    run = 1'b0;
    @(negedge clk);
    pulse_clear();
    chk("sat.clear", {15'd0, sat1}, 16'd0);

    // pause freezes time and frame count
    run = 1'b1;
    @(negedge clk);
    ticks(30);
    pause = 1'b1;
    @(negedge clk);
    ticks(100);
    chk("pause.time", t1, 16'h0000);
    chk("pause.state", {14'd0, st1}, 16'd2);
    pause = 1'b0;
    @(negedge clk);
    ticks(29);
    chk("pause.held", t1, 16'h0000);
    ticks(1);
    chk("pause.resume", t1, 16'h0001);
    ticks(60);
    ticks(59);
    chk("pre_clear", t1, 16'h0002);
    vsync = 1'b1;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    vsync = 1'b0;
    @(negedge clk);
    chk("clear_tick.time", t1, 16'h0000);
    ticks(59);
    chk("clear_tick.drop", t1, 16'h0000);
    ticks(1);
    chk("clear_tick.next", t1, 16'h0001);
    pulse_load(16'h0500);
    @(negedge clk);
    chk("load_in_run", t1, 16'h0001);

    // asynchronous reset between edges
    #2 rst = 1'b0;
    #1;
    chk("arst.time", t1, 16'h0000);
    chk("arst.best", b1, 16'h0000);
    chk("arst.state", {14'd0, st1}, 16'd0);
    chk("arst.flags", {13'd0, nb1, ex1, sat1}, 16'd0);
    run = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      pulse_load(vecs[i].ld);
      chk($sformatf("clamp[%0d]", i), t1, vecs[i].exp);
    end

    for (int i = 0; i < 4000; i++) begin
      vsync = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) run = !run;
      if ($urandom_range(0, 19) == 0) pause = !pause;
      if ($urandom_range(0, 9) == 0) mode_down = !mode_down;
      clear = ($urandom_range(0, 59) == 0);
      load = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 1) == 1) load_bcd = 16'($urandom);
      else load_bcd = {12'h000, 4'($urandom_range(0, 4))};
      @(posedge clk);
      #1;
      chk_models();
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
